// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA256d nonce sequencer.
// Contents:
//   word_t / digest_t / block_t - SHA-256 word, 8-word digest, 16-word message block
//   PAD_WORD, BLK2_LEN, DIG_LEN - padding word and message bit lengths
//   state_e                     - sequencer FSM states
//   pad_sel_e                   - message block selector for sha256d_pad
package sha256_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [0:7]  digest_t;
   typedef word_t [0:15] block_t;

   localparam int unsigned HDR_WORDS = 19;
   localparam word_t PAD_WORD = 32'h80000000;
   // Message bit lengths: 80-byte header, then the 32-byte first digest.
   localparam word_t BLK2_LEN = 32'h00000280;
   localparam word_t DIG_LEN  = 32'h00000100;

   typedef enum logic [2:0] {
      StIdle,
      StB1Go,
      StB1Wait,
      StB2Go,
      StB2Wait,
      StH2Go,
      StH2Wait,
      StOut
   } state_e;

   typedef enum logic {
      PadBlk2,
      PadDigest
   } pad_sel_e;

endpackage

// File: rtl/sha256d_pad.sv
// Combinational builder for the two padded message blocks used per nonce.
// Ports:
//   sel      - PadBlk2: header block 2 with nonce; PadDigest: padded 256-bit digest
//   hdr_tail - header words 16..18
//   nonce    - nonce word (header word 19)
//   digest   - first-pass digest to be hashed again
//   block    - resulting 16-word message block
module sha256d_pad
   import sha256_pkg::*;
(
   input  pad_sel_e              sel,
   input  logic [0:2][31:0]      hdr_tail,
   input  logic [31:0]           nonce,
   input  logic [0:7][31:0]      digest,
   output logic [0:15][31:0]     block
);

   always_comb begin
      block = '0;
      unique case (sel)
         PadDigest: begin
            for (int i = 0; i < 8; i++) begin
               block[i] = digest[i];
            end
            block[8]  = PAD_WORD;
            block[15] = DIG_LEN;
         end
         default: begin
            block[0]  = hdr_tail[0];
            block[1]  = hdr_tail[1];
            block[2]  = hdr_tail[2];
            block[3]  = nonce;
            block[4]  = PAD_WORD;
            block[15] = BLK2_LEN;
         end
      endcase
   end

endmodule

// File: rtl/sha256d_nonce_sequencer.sv
// Drives one SHA-256 compression core to compute SHA256d of an 80-byte block
// header over a range of nonces. Header block 1 is compressed once per job to
// obtain the midstate; each nonce then costs one chained block-2 pass and one
// pass over the padded first digest.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - job start pulse (honoured only when idle)
//   header[0:18]               - fixed header words, latched at start
//   nonce_base, nonce_count    - first nonce and number of nonces, latched at start
//   busy, job_done             - job in progress / one-cycle end-of-job pulse
//   res_valid/res_ready        - result handshake
//   res_nonce, res_hash[0:7]   - nonce and SHA256d digest of the current result
//   core_start, core_switch    - core pulse and chaining select (1 = use core_in)
//   core_message[0:15], core_in[0:7] - block and chaining value to the core
//   core_done, core_result[0:7]      - core completion pulse and digest
module sha256d_nonce_sequencer
   import sha256_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [0:HDR_WORDS-1][31:0]  header,
   input  logic [31:0]                 nonce_base,
   input  logic [31:0]                 nonce_count,
   output logic                        busy,
   output logic                        job_done,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [31:0]                 res_nonce,
   output logic [0:7][31:0]            res_hash,
   output logic                        core_start,
   output logic                        core_switch,
   output logic [0:15][31:0]           core_message,
   output logic [0:7][31:0]            core_in,
   input  logic                        core_done,
   input  logic [0:7][31:0]            core_result
);

   state_e                       state;
   logic [0:HDR_WORDS-1][31:0]   hdr_q;
   word_t                        nonce;
   word_t                        remaining;
   digest_t                      midstate;
   pad_sel_e                     pad_sel;
   block_t                       pad_block;

   // The digest pad reads core_result directly: the core keeps its result
   // until the next core_start, which is the H2_GO cycle itself.
   assign pad_sel = (state == StH2Go || state == StH2Wait) ? PadDigest : PadBlk2;

   sha256d_pad u_pad (
      .sel      (pad_sel),
      .hdr_tail (hdr_q[16:18]),
      .nonce    (nonce),
      .digest   (core_result),
      .block    (pad_block)
   );

   always_comb begin
      core_message = pad_block;
      if (state == StB1Go || state == StB1Wait) begin
         core_message = hdr_q[0:15];
      end
   end

   assign core_in = midstate;

   // core_start/core_switch are registered on entry to each *_GO state so they
   // are high exactly during the GO cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         busy        <= 1'b0;
         job_done    <= 1'b0;
         res_valid   <= 1'b0;
         res_nonce   <= '0;
         res_hash    <= '0;
         core_start  <= 1'b0;
         core_switch <= 1'b0;
         midstate    <= '0;
         nonce       <= '0;
         remaining   <= '0;
         hdr_q       <= '0;
      end else begin
         job_done   <= 1'b0;
         core_start <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  if (nonce_count == 32'd0) begin
                     job_done <= 1'b1;
                  end else begin
                     hdr_q       <= header;
                     nonce       <= nonce_base;
                     remaining   <= nonce_count;
                     busy        <= 1'b1;
                     core_start  <= 1'b1;
                     core_switch <= 1'b0;
                     state       <= StB1Go;
                  end
               end
            end
            StB1Go: state <= StB1Wait;
            StB1Wait: begin
               if (core_done) begin
                  midstate    <= core_result;
                  core_start  <= 1'b1;
                  core_switch <= 1'b1;
                  state       <= StB2Go;
               end
            end
            StB2Go: state <= StB2Wait;
            StB2Wait: begin
               if (core_done) begin
                  core_start  <= 1'b1;
                  core_switch <= 1'b0;
                  state       <= StH2Go;
               end
            end
            StH2Go: state <= StH2Wait;
            StH2Wait: begin
               if (core_done) begin
                  res_hash  <= core_result;
                  res_nonce <= nonce;
                  res_valid <= 1'b1;
                  state     <= StOut;
               end
            end
            StOut: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  remaining <= remaining - 32'd1;
                  if (remaining == 32'd1) begin
                     job_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= StIdle;
                  end else begin
                     nonce       <= nonce + 32'd1;
                     core_start  <= 1'b1;
                     core_switch <= 1'b1;
                     state       <= StB2Go;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256d_nonce_sequencer.sv
// Self-checking bench: a behavioural SHA-256 compression core answers the
// sequencer, and results are compared with a byte-level SHA256d reference.
module tb_sha256d_nonce_sequencer;

   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   logic [31:0] k_tab [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset, start;
   logic [0:18][31:0]   header;
   logic [31:0]         nonce_base, nonce_count;
   logic                busy, job_done, res_valid, res_ready;
   logic [31:0]         res_nonce;
   logic [0:7][31:0]    res_hash;
   logic                core_start, core_switch;
   logic [0:15][31:0]   core_message;
   logic [0:7][31:0]    core_in;
   logic                core_done = 1'b0;
   logic [0:7][31:0]    core_result = '0;

   sha256d_nonce_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .header       (header),
      .nonce_base   (nonce_base),
      .nonce_count  (nonce_count),
      .busy         (busy),
      .job_done     (job_done),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_nonce    (res_nonce),
      .res_hash     (res_hash),
      .core_start   (core_start),
      .core_switch  (core_switch),
      .core_message (core_message),
      .core_in      (core_in),
      .core_done    (core_done),
      .core_result  (core_result)
   );

   // ---------------- SHA-256 reference ----------------
   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
      e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   function automatic logic [255:0] sha256_bytes(input logic [7:0] m [$]);
      logic [7:0]   p [$];
      logic [63:0]  bits;
      logic [511:0] blk;
      logic [255:0] h;
      p = m;
      bits = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      h = IV;
      for (int b = 0; b < p.size() / 64; b++) begin
         for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
         h = compress(h, blk);
      end
      return h;
   endfunction

   function automatic logic [255:0] sha256d_ref(input logic [0:18][31:0] h, input logic [31:0] n);
      logic [7:0]   q [$];
      logic [255:0] d;
      for (int w = 0; w < 19; w++)
         for (int k = 3; k >= 0; k--) q.push_back(h[w][8*k +: 8]);
      for (int k = 3; k >= 0; k--) q.push_back(n[8*k +: 8]);
      d = sha256_bytes(q);
      q.delete();
      for (int j = 0; j < 32; j++) q.push_back(d[255 - 8*j -: 8]);
      return sha256_bytes(q);
   endfunction

   // ---------------- core model and monitors ----------------
   int            cyc = 0;
   logic          core_busy = 1'b0;
   int            core_cnt = 0;
   logic [255:0]  core_pend = '0;
   int            n_start = 0, n_overlap = 0, n_jobdone = 0, xfer_cyc = 0, jd_cyc = 0;
   bit            start_sw [$];
   logic [511:0]  start_msg [$];
   logic [255:0]  start_in [$];
   logic [31:0]   got_nonce [$];
   logic [255:0]  got_hash [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      core_done <= 1'b0;
      if (reset) begin
         core_busy <= 1'b0;
      end else if (core_start) begin
         if (core_busy) n_overlap <= n_overlap + 1;
         n_start <= n_start + 1;
         start_sw.push_back(core_switch);
         start_msg.push_back(core_message);
         start_in.push_back(core_in);
         core_pend <= compress(core_switch ? core_in : IV, core_message);
         // Result is undefined while the core runs.
         for (int k = 0; k < 8; k++) core_result[k] <= $urandom;
         core_cnt  <= $urandom_range(8, 66);
         core_busy <= 1'b1;
      end else if (core_busy) begin
         if (core_cnt == 0) begin
            core_done   <= 1'b1;
            core_result <= core_pend;
            core_busy   <= 1'b0;
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
      if (res_valid && res_ready) begin
         got_nonce.push_back(res_nonce);
         got_hash.push_back(res_hash);
         xfer_cyc <= cyc;
      end
      if (job_done) begin
         n_jobdone <= n_jobdone + 1;
         jd_cyc    <= cyc;
      end
   end

   // ---------------- checking and stimulus ----------------
   int n_checks = 0, n_fail = 0;
   bit rand_ready = 1'b0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_hdr(output logic [0:18][31:0] h);
      for (int i = 0; i < 19; i++) h[i] = $urandom;
   endtask

   task automatic start_job(input logic [0:18][31:0] h, input logic [31:0] base,
                            input logic [31:0] cnt);
      logic [0:18][31:0] junk;
      header = h; nonce_base = base; nonce_count = cnt; start = 1'b1;
      step();
      start = 1'b0;
      // Scramble inputs: the job must run on the latched copies.
      rand_hdr(junk);
      header = junk; nonce_base = $urandom; nonce_count = $urandom;
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20000 && !ok; i++) begin
         if (rand_ready) res_ready = 1'($urandom_range(0, 1));
         step();
         if (job_done) ok = 1'b1;
      end
      check({tag, "_done"}, 256'(ok), 256'd1);
      step();
   endtask

   task automatic compare_results(input string tag, input logic [0:18][31:0] h,
                                  input logic [31:0] base, input int cnt, input int b0);
      logic [31:0] n;
      check({tag, "_count"}, 256'(got_nonce.size() - b0), 256'(cnt));
      for (int i = 0; i < cnt && b0 + i < got_nonce.size(); i++) begin
         n = base + 32'(i);
         check($sformatf("%s_nonce%0d", tag, i), 256'(got_nonce[b0 + i]), 256'(n));
         check($sformatf("%s_hash%0d", tag, i), got_hash[b0 + i], sha256d_ref(h, n));
      end
   endtask

   task automatic wait_starts(input string tag, input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         step();
         if (n_start >= target) ok = 1'b1;
      end
      check({tag, "_starts_seen"}, 256'(ok), 256'd1);
   endtask

   logic [0:18][31:0] g_hdr, ha, hb, hc, hd;
   logic [31:0]       base, snap_n;
   logic [255:0]      snap_h;
   int                b0, s0, jd0, diffs, cnt_sw0, cnt_sw0_hdr, cnt_sw1;
   bit                seen;

   initial begin
      reset = 1'b1; start = 1'b0; header = '0; nonce_base = '0; nonce_count = '0;
      res_ready = 1'b0;
      repeat (3) step();
      check("rst_busy", 256'(busy), 256'd0);
      check("rst_job_done", 256'(job_done), 256'd0);
      check("rst_res_valid", 256'(res_valid), 256'd0);
      check("rst_core_start", 256'(core_start), 256'd0);
      check("rst_core_switch", 256'(core_switch), 256'd0);
      check("rst_res_nonce", 256'(res_nonce), 256'd0);
      check("rst_res_hash", res_hash, 256'd0);
      reset = 1'b0;
      step();

      // Genesis header.
      g_hdr = {32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
               32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
      b0 = got_nonce.size(); s0 = start_sw.size();
      res_ready = 1'b1;
      start_job(g_hdr, 32'h1dac2b7c, 32'd1);
      check("gen_busy", 256'(busy), 256'd1);
      wait_done("gen");
      compare_results("gen", g_hdr, 32'h1dac2b7c, 1, b0);
      if (got_hash.size() > b0)
         check("gen_known_hash", got_hash[b0],
               256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000);
      check("gen_jd_latency", 256'(jd_cyc - xfer_cyc), 256'd1);
      check("gen_starts", 256'(start_sw.size() - s0), 256'd3);
      check("gen_busy_after", 256'(busy), 256'd0);

      // Midstate reuse with random backpressure.
      rand_hdr(ha);
      b0 = got_nonce.size(); s0 = start_sw.size();
      rand_ready = 1'b1;
      start_job(ha, 32'd5, 32'd4);
      wait_done("mid");
      rand_ready = 1'b0; res_ready = 1'b1;
      compare_results("mid", ha, 32'd5, 4, b0);
      check("mid_starts", 256'(start_sw.size() - s0), 256'd9);
      cnt_sw0 = 0; cnt_sw0_hdr = 0; cnt_sw1 = 0;
      for (int i = s0; i < start_sw.size(); i++) begin
         if (start_sw[i]) cnt_sw1++;
         else begin
            cnt_sw0++;
            if (start_msg[i] == 512'(ha[0:15])) cnt_sw0_hdr++;
         end
      end
      check("mid_first_sw", 256'(start_sw[s0]), 256'd0);
      check("mid_first_msg", 256'(start_msg[s0] == 512'(ha[0:15])), 256'd1);
      check("mid_hdr_passes", 256'(cnt_sw0_hdr), 256'd1);
      check("mid_chained_passes", 256'(cnt_sw1), 256'd4);
      check("mid_midstate", start_in[s0 + 1], compress(IV, 512'(ha[0:15])));

      // Backpressure.
      rand_hdr(hb);
      base = $urandom;
      b0 = got_nonce.size();
      res_ready = 1'b0;
      start_job(hb, base, 32'd3);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         step();
         if (res_valid) seen = 1'b1;
      end
      check("bp_valid_seen", 256'(seen), 256'd1);
      snap_n = res_nonce; snap_h = res_hash; s0 = n_start; diffs = 0;
      repeat (200) begin
         step();
         if (res_valid !== 1'b1 || res_nonce !== snap_n || res_hash !== snap_h) diffs++;
      end
      check("bp_stable", 256'(diffs), 256'd0);
      check("bp_no_start", 256'(n_start - s0), 256'd0);
      check("bp_no_xfer", 256'(got_nonce.size() - b0), 256'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      step();
      check("bp_one_xfer", 256'(got_nonce.size() - b0), 256'd1);
      check("bp_valid_low", 256'(res_valid), 256'd0);
      wait_starts("bp_resume", s0 + 1);
      res_ready = 1'b1;
      wait_done("bp");
      compare_results("bp", hb, base, 3, b0);

      // Nonce wrap.
      rand_hdr(hc);
      b0 = got_nonce.size();
      start_job(hc, 32'hFFFFFFFF, 32'd2);
      wait_done("wrap");
      compare_results("wrap", hc, 32'hFFFFFFFF, 2, b0);
      if (got_nonce.size() >= b0 + 2)
         check("wrap_zero", 256'(got_nonce[b0 + 1]), 256'h0);

      // Zero count.
      b0 = got_nonce.size(); s0 = n_start; jd0 = n_jobdone;
      start_job(hc, 32'd9, 32'd0);
      check("zero_jd", 256'(job_done), 256'd1);
      check("zero_busy", 256'(busy), 256'd0);
      repeat (10) step();
      check("zero_jd_count", 256'(n_jobdone - jd0), 256'd1);
      check("zero_no_start", 256'(n_start - s0), 256'd0);
      check("zero_no_xfer", 256'(got_nonce.size() - b0), 256'd0);

      // Start while busy is ignored.
      rand_hdr(hc); rand_hdr(hd);
      base = $urandom;
      b0 = got_nonce.size(); s0 = n_start; jd0 = n_jobdone;
      start_job(hc, base, 32'd2);
      wait_starts("sb", s0 + 2);
      repeat (3) step();
      start_job(hd, base + 32'd100, 32'd5);
      wait_done("sb");
      compare_results("sb", hc, base, 2, b0);
      check("sb_starts", 256'(n_start - s0), 256'd5);
      check("sb_jd_count", 256'(n_jobdone - jd0), 256'd1);

      // Reset during the digest pass.
      rand_hdr(hd);
      s0 = n_start; b0 = got_nonce.size();
      start_job(hd, 32'd77, 32'd3);
      wait_starts("rst", s0 + 3);
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rmid_busy", 256'(busy), 256'd0);
      check("rmid_valid", 256'(res_valid), 256'd0);
      check("rmid_core_start", 256'(core_start), 256'd0);
      check("rmid_res_hash", res_hash, 256'd0);
      jd0 = n_jobdone;
      repeat (80) step();
      check("rmid_no_jd", 256'(n_jobdone - jd0), 256'd0);
      check("rmid_no_xfer", 256'(got_nonce.size() - b0), 256'd0);

      // Fresh job after reset.
      rand_hdr(hd);
      base = $urandom;
      b0 = got_nonce.size();
      start_job(hd, base, 32'd2);
      wait_done("fresh");
      compare_results("fresh", hd, base, 2, b0);

      check("core_overlap", 256'(n_overlap), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
